// File: rtl/mips_dbus_responder.sv
// Data-side bus responder for the MIPS core: word RAM plus an I/O page with
// a compare timer and a byte transmit FIFO drained over valid/ready.
module mips_dbus_responder #(
    parameter int          RAM_WORDS = 1024,
    parameter int          TX_DEPTH  = 8,
    parameter logic [31:0] IO_BASE   = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [CNT_W-1:0] FIFO_MAX  = CNT_W'(TX_DEPTH);

    localparam logic [5:0] OFF_COUNT  = 6'h00;
    localparam logic [5:0] OFF_CMP    = 6'h01;
    localparam logic [5:0] OFF_CTRL   = 6'h02;
    localparam logic [5:0] OFF_TXDATA = 6'h04;
    localparam logic [5:0] OFF_TXSTAT = 6'h05;

    logic             ram_hit;
    logic             io_hit;
    logic [IDX_W-1:0] ram_idx;
    logic [5:0]       io_off;
    logic             io_wr;
    logic             wr_count, wr_cmp, wr_ctrl, wr_txstat, push_req;

    assign ram_hit   = memaddr < RAM_BYTES;
    assign ram_idx   = memaddr[IDX_W+1:2];
    assign io_hit    = memaddr[31:8] == IO_BASE[31:8];
    assign io_off    = memaddr[7:2];
    assign io_wr     = memwrite && io_hit;
    assign wr_count  = io_wr && (io_off == OFF_COUNT);
    assign wr_cmp    = io_wr && (io_off == OFF_CMP);
    assign wr_ctrl   = io_wr && (io_off == OFF_CTRL);
    assign wr_txstat = io_wr && (io_off == OFF_TXSTAT);
    assign push_req  = io_wr && (io_off == OFF_TXDATA);

    // RAM contents survive reset, so this array has no reset branch.
    logic [31:0] ram_q [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (memwrite && ram_hit) begin
            ram_q[ram_idx] <= memwritedata;
        end
    end

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        flag_q, flag_d;
    logic        irq_q;
    logic        timer_match;

    assign timer_match = ctrl_q[0] && (count_q == cmp_q);

    always_comb begin
        count_d = count_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        flag_d  = flag_q;
        if (wr_count) begin
            count_d = memwritedata;
        end else if (timer_match) begin
            count_d = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
        end else if (ctrl_q[0]) begin
            count_d = count_q + 32'd1;
        end
        if (wr_cmp) begin
            cmp_d = memwritedata;
        end
        if (wr_ctrl) begin
            ctrl_d = memwritedata[2:0];
        end
        // A match in the same cycle as the W1C write keeps the flag set.
        if (timer_match) begin
            flag_d = 1'b1;
        end else if (wr_ctrl && memwritedata[3]) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            flag_q  <= flag_d;
            irq_q   <= flag_d & ctrl_d[2];
        end
    end

    assign irq = irq_q;

    logic [7:0]       fifo_q [TX_DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             ovf_q, ovf_d;
    logic             fifo_full, fifo_empty, pop, push;

    assign fifo_full  = fcnt_q == FIFO_MAX;
    assign fifo_empty = fcnt_q == '0;
    assign pop        = !fifo_empty && tx_ready;
    assign push       = push_req && (!fifo_full || pop);

    always_comb begin
        rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
        fcnt_d = fcnt_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d  = ovf_q;
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (wr_txstat && memwritedata[10]) begin
            ovf_d = 1'b0;
        end
    end

    // Storage needs no reset: the head byte is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= memwritedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q <= '0;
            wptr_q <= '0;
            fcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            fcnt_q <= fcnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rptr_q];

    logic [31:0] tx_status;
    assign tx_status = {21'd0, ovf_q, fifo_empty, fifo_full, 3'd0, 5'(fcnt_q)};

    always_comb begin
        memreaddata = 32'd0;
        if (ram_hit) begin
            memreaddata = ram_q[ram_idx];
        end else if (io_hit) begin
            case (io_off)
                OFF_COUNT:  memreaddata = count_q;
                OFF_CMP:    memreaddata = cmp_q;
                OFF_CTRL:   memreaddata = {28'd0, flag_q, ctrl_q};
                OFF_TXSTAT: memreaddata = tx_status;
                default:    memreaddata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dbus_responder.sv
// Bench for mips_dbus_responder: a queue/integer model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mips_dbus_responder;

    localparam int          DEPTH = 8;
    localparam logic [31:0] IO    = 32'hFFFF0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        irq;

    int nchk = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    mips_dbus_responder #(.RAM_WORDS(1024), .TX_DEPTH(DEPTH), .IO_BASE(IO)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
        .memwritedata(memwritedata), .memreaddata(memreaddata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_cnt, m_cmp;
    bit          m_en, m_ac, m_ie, m_flag, m_irq, m_ovf;
    logic [7:0]  q[$];
    logic [31:0] m_ram [int];

    logic [31:0] ma;
    logic [7:0]  moff;
    bit          mio, mw, mmatch, mpush, movf_set;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_cmp = 0; m_en = 0; m_ac = 0; m_ie = 0;
            m_flag = 0; m_irq = 0; m_ovf = 0;
            q.delete();
        end else begin
            ma = memaddr; mw = memwrite;
            mio = (ma[31:8] == IO[31:8]);
            moff = {ma[7:2], 2'b00};
            mmatch = m_en && (m_cnt == m_cmp);
            if (mw && mio && moff == 8'h00) m_cnt = memwritedata;
            else if (mmatch) m_cnt = m_ac ? 32'd0 : m_cnt + 32'd1;
            else if (m_en) m_cnt = m_cnt + 32'd1;
            if (mw && mio && moff == 8'h04) m_cmp = memwritedata;
            if (mw && mio && moff == 8'h08) begin
                m_en = memwritedata[0]; m_ac = memwritedata[1]; m_ie = memwritedata[2];
            end
            if (mmatch) m_flag = 1;
            else if (mw && mio && moff == 8'h08 && memwritedata[3]) m_flag = 0;
            m_irq = m_flag & m_ie;
            if (q.size() > 0 && tx_ready) void'(q.pop_front());
            mpush = mw && mio && moff == 8'h10;
            movf_set = 0;
            if (mpush) begin
                if (q.size() < DEPTH) q.push_back(memwritedata[7:0]);
                else movf_set = 1;
            end
            if (movf_set) m_ovf = 1;
            else if (mw && mio && moff == 8'h14 && memwritedata[10]) m_ovf = 0;
            if (mw && ma < 32'h1000) m_ram[int'(ma[11:2])] = memwritedata;
        end
    end

    // Returns {known, value} for a read at address a.
    function automatic logic [32:0] model_read(input logic [31:0] a);
        logic [7:0] o;
        o = {a[7:2], 2'b00};
        if (a < 32'h1000) begin
            if (m_ram.exists(int'(a[11:2]))) return {1'b1, m_ram[int'(a[11:2])]};
            return {1'b0, 32'd0};
        end
        if (a[31:8] != IO[31:8]) return {1'b1, 32'd0};
        case (o)
            8'h00: return {1'b1, m_cnt};
            8'h04: return {1'b1, m_cmp};
            8'h08: return {1'b1, 28'd0, m_flag, m_ie, m_ac, m_en};
            8'h14: return {1'b1, 21'd0, m_ovf, q.size() == 0, q.size() == DEPTH,
                           3'd0, 5'(q.size())};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [32:0] mr;
    always @(negedge clk) begin
        if (chk_on && !reset) begin
            chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
            chk("tx_data", 32'(tx_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
            chk("irq", 32'(irq), 32'(m_irq));
            mr = model_read(memaddr);
            if (mr[32]) chk("memreaddata", memreaddata, mr[31:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; memaddr = a; memwritedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        memaddr = a;
        #1;
        chk(nm, memreaddata, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] wrap_seq [5];

    initial begin
        reset = 1'b1; memwrite = 1'b0; memaddr = 32'h0000_2000;
        memwritedata = 32'd0; tx_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_on = 1'b1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd("rst_status", IO + 32'h14, 32'h200);
        rd("rst_count", IO, 32'd0);

        // RAM
        wr(32'h10, 32'hDEADBEEF);
        wr(32'hFFC, 32'h12345678);
        rd("ram_10", 32'h10, 32'hDEADBEEF);
        rd("ram_ffc", 32'hFFC, 32'h12345678);
        rd("ram_oob", 32'h1000, 32'd0);
        memwrite = 1'b1; memaddr = 32'h10; memwritedata = 32'h1111_2222;
        #1;
        chk("ram_rdw_old", memreaddata, 32'hDEADBEEF);
        tick();
        memwrite = 1'b0;
        rd("ram_rdw_new", 32'h10, 32'h1111_2222);
        wr(32'h10, 32'hDEADBEEF);

        // Timer with autoclear and irq
        wr(IO + 32'h4, 32'd5);
        wr(IO, 32'd0);
        wr(IO + 32'h8, 32'h7);
        rd("tmr_start", IO, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("tmr_count", memreaddata, 32'(k % 6));
            chk("tmr_irq", 32'(irq), 32'(k >= 6));
        end
        wr(IO + 32'h8, 32'h8);
        rd("tmr_clr_ctrl", IO + 32'h8, 32'h0);
        chk("tmr_clr_irq", 32'(irq), 32'd0);

        // W1C clear coinciding with a match
        wr(IO, 32'd3);
        wr(IO + 32'h8, 32'h1);
        tick(); tick();
        rd("tmr_at_cmp", IO, 32'd5);
        wr(IO + 32'h8, 32'h9);
        rd("tmr_clr_loses", IO + 32'h8, 32'h9);
        wr(IO + 32'h8, 32'h8);
        rd("tmr_clr2", IO + 32'h8, 32'h0);

        // Timer wrap
        wrap_seq = '{32'hFFFFFFFF, 32'd0, 32'd1, 32'd2, 32'd3};
        wr(IO, 32'hFFFFFFFE);
        wr(IO + 32'h4, 32'd3);
        wr(IO + 32'h8, 32'h1);
        rd("wrap_start", IO, 32'hFFFFFFFE);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("wrap_count", memreaddata, wrap_seq[k]);
        end
        tick();
        rd("wrap_flag", IO + 32'h8, 32'h9);
        chk("wrap_irq", 32'(irq), 32'd0);
        wr(IO + 32'h8, 32'h8);

        // FIFO fill, overflow, drain
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(IO + 32'h10, 32'h41 + 32'(i));
        rd("fifo_full", IO + 32'h14, 32'h108);
        wr(IO + 32'h10, 32'h49);
        rd("fifo_ovf", IO + 32'h14, 32'h508);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 32'(tx_valid), 32'd1);
            chk("drain_data", 32'(tx_data), 32'h41 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        rd("fifo_empty_ovf", IO + 32'h14, 32'h600);
        wr(IO + 32'h14, 32'h400);
        rd("fifo_ovf_clr", IO + 32'h14, 32'h200);

        // Push into a full FIFO while popping
        for (int i = 0; i < 8; i++) wr(IO + 32'h10, 32'h50 + 32'(i));
        tx_ready = 1'b1;
        wr(IO + 32'h10, 32'h5A);
        tx_ready = 1'b0;
        rd("full_pushpop", IO + 32'h14, 32'h108);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pp_data", 32'(tx_data), (i == 7) ? 32'h5A : 32'h51 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;

        // No bypass into an empty FIFO
        memwrite = 1'b1; memaddr = IO + 32'h10; memwritedata = 32'h33;
        #1;
        chk("nobypass_valid0", 32'(tx_valid), 32'd0);
        tick();
        memwrite = 1'b0;
        chk("nobypass_valid1", 32'(tx_valid), 32'd1);
        chk("nobypass_data", 32'(tx_data), 32'h33);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        // Reset mid-operation
        for (int i = 0; i < 3; i++) wr(IO + 32'h10, 32'h70 + 32'(i));
        wr(IO + 32'h4, 32'd100);
        wr(IO + 32'h8, 32'h7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_valid", 32'(tx_valid), 32'd0);
        chk("mrst_data", 32'(tx_data), 32'd0);
        chk("mrst_irq", 32'(irq), 32'd0);
        rd("mrst_count", IO, 32'd0);
        rd("mrst_cmp", IO + 32'h4, 32'd0);
        rd("mrst_ctrl", IO + 32'h8, 32'd0);
        rd("mrst_status", IO + 32'h14, 32'h200);
        rd("mrst_ram", 32'h10, 32'hDEADBEEF);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
